// File: rtl/wbu_commit_pkg.sv
// Shared types for the write-back/commit stage: FSM states, control-flow class
// encoding and the instruction length used for sequential PC.
package wbu_commit_pkg;

    localparam int ILEN_BYTES = 4;

    typedef enum logic [1:0] {
        WBU_IDLE,
        WBU_COMMIT,
        WBU_HOLD
    } wbu_state_e;

    typedef enum logic [2:0] {
        BR_SEQ,
        BR_TAKEN,
        BR_JALR,
        BR_JAL,
        BR_MRET,
        BR_ECALL
    } br_class_e;

    // Folds the one-hot control-flow flags into a single class, highest priority first,
    // so a malformed entry with several flags set still resolves deterministically.
    function automatic br_class_e encode_class(input logic brch, input logic jal,
                                               input logic jalr, input logic mret,
                                               input logic ecall, input logic taken);
        if (ecall)              return BR_ECALL;
        else if (mret)          return BR_MRET;
        else if (jal)           return BR_JAL;
        else if (jalr)          return BR_JALR;
        else if (brch && taken) return BR_TAKEN;
        else                    return BR_SEQ;
    endfunction

endpackage

// File: rtl/wbu_npc.sv
// Combinational next-PC and GPR write-data selection for one committed entry.
module wbu_npc
    import wbu_commit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  br_class_e         cls,
    input  logic              link,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   res,
    input  logic [XLEN-1:0]   mepc,
    input  logic [XLEN-1:0]   mtvec,
    output logic [XLEN-1:0]   pc_next,
    output logic [XLEN-1:0]   rd_wdata
);

    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] pc_rel;
    logic [XLEN-1:0] jalr_sum;

    assign seq_pc   = pc + XLEN'(ILEN_BYTES);
    assign pc_rel   = pc + imm;
    assign jalr_sum = rs1 + imm;

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pc_next = seq_pc;
        case (cls)
            BR_ECALL: pc_next = mtvec;
            BR_MRET:  pc_next = mepc;
            BR_JAL:   pc_next = pc_rel;
            BR_JALR:  pc_next = {jalr_sum[XLEN-1:1], 1'b0};
            BR_TAKEN: pc_next = pc_rel;
            default:  pc_next = seq_pc;
        endcase
    end

    assign rd_wdata = link ? seq_pc : res;

endmodule

// File: rtl/wbu_commit.sv
// Registered write-back/commit stage with next-PC hold toward the fetch unit.
// Optional retired-instruction counter enabled by defining WBU_INSTRET_EN.
module wbu_commit
    import wbu_commit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h3000_0000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_pre_valid,
    output logic              o_pre_ready,
    input  logic              i_wen,
    input  logic              i_csr_wen,
    input  logic              i_brch,
    input  logic              i_jal,
    input  logic              i_jalr,
    input  logic              i_mret,
    input  logic              i_ecall,
    input  logic [XLEN-1:0]   i_pc,
    input  logic [XLEN-1:0]   i_rs1,
    input  logic [XLEN-1:0]   i_imm,
    input  logic [XLEN-1:0]   i_res,
    input  logic [XLEN-1:0]   i_mepc,
    input  logic [XLEN-1:0]   i_mtvec,
    output logic [XLEN-1:0]   o_rd_wdata,
    output logic [XLEN-1:0]   o_csr_rd,
    output logic              o_wbu_wen,
    output logic              o_wbu_csr_wen,
    output logic              o_pc_update,
    input  logic              i_pc_ready,
    output logic [XLEN-1:0]   o_pc_next,
    output logic              o_misalign
`ifdef WBU_INSTRET_EN
    ,
    output logic [63:0]       o_instret
`endif
);

    typedef struct packed {
        logic            wen;
        logic            csr_wen;
        logic            link;
        br_class_e       cls;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] res;
        logic [XLEN-1:0] mepc;
        logic [XLEN-1:0] mtvec;
    } entry_t;

    // The fetch side boots from RESET_PC; an unaligned value would fault on the first fetch.
    if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_check
        $error("RESET_PC must be word aligned");
    end

    wbu_state_e state;
    wbu_state_e state_next;
    entry_t     entry;
    logic       capture;

    assign o_pre_ready = (state == WBU_IDLE) || i_pc_ready;
    assign capture     = i_pre_valid && o_pre_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= WBU_IDLE;
            entry <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                entry.wen     <= i_wen;
                entry.csr_wen <= i_csr_wen;
                entry.link    <= i_jal || i_jalr;
                entry.cls     <= encode_class(i_brch, i_jal, i_jalr, i_mret, i_ecall, i_res[0]);
                entry.pc      <= i_pc;
                entry.rs1     <= i_rs1;
                entry.imm     <= i_imm;
                entry.res     <= i_res;
                entry.mepc    <= i_mepc;
                entry.mtvec   <= i_mtvec;
            end
        end
    end

    // Write enables fire only in COMMIT, so a long HOLD never repeats a register write.
    always_comb begin
        state_next    = state;
        o_wbu_wen     = 1'b0;
        o_wbu_csr_wen = 1'b0;
        o_pc_update   = 1'b0;
        case (state)
            WBU_IDLE: begin
                if (capture) state_next = WBU_COMMIT;
            end
            WBU_COMMIT, WBU_HOLD: begin
                o_pc_update = 1'b1;
                if (state == WBU_COMMIT) begin
                    o_wbu_wen     = entry.wen;
                    o_wbu_csr_wen = entry.csr_wen;
                end
                if (!i_pc_ready)  state_next = WBU_HOLD;
                else if (capture) state_next = WBU_COMMIT;
                else              state_next = WBU_IDLE;
            end
            default: state_next = WBU_IDLE;
        endcase
    end

    wbu_npc #(.XLEN(XLEN)) u_npc (
        .cls      (entry.cls),
        .link     (entry.link),
        .pc       (entry.pc),
        .rs1      (entry.rs1),
        .imm      (entry.imm),
        .res      (entry.res),
        .mepc     (entry.mepc),
        .mtvec    (entry.mtvec),
        .pc_next  (o_pc_next),
        .rd_wdata (o_rd_wdata)
    );

    assign o_csr_rd   = entry.res;
    assign o_misalign = o_pc_update && (o_pc_next[1:0] != 2'b00);

`ifdef WBU_INSTRET_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            o_instret <= '0;
        end else if (o_pc_update && i_pc_ready) begin
            o_instret <= o_instret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wbu_commit.sv
// Scoreboard bench for wbu_commit: expected commits are queued at handshake and
// compared when the stage presents them; o_instret is checked when WBU_INSTRET_EN is defined.
module tb_wbu_commit;

    localparam int XLEN = 32;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            i_pre_valid, o_pre_ready;
    logic            i_wen, i_csr_wen, i_brch, i_jal, i_jalr, i_mret, i_ecall;
    logic [XLEN-1:0] i_pc, i_rs1, i_imm, i_res, i_mepc, i_mtvec;
    logic [XLEN-1:0] o_rd_wdata, o_csr_rd, o_pc_next;
    logic            o_wbu_wen, o_wbu_csr_wen, o_pc_update, i_pc_ready, o_misalign;
`ifdef WBU_INSTRET_EN
    logic [63:0]     o_instret;
`endif

    always #5 clock = ~clock;

    wbu_commit #(.XLEN(XLEN)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .i_pre_valid   (i_pre_valid),
        .o_pre_ready   (o_pre_ready),
        .i_wen         (i_wen),
        .i_csr_wen     (i_csr_wen),
        .i_brch        (i_brch),
        .i_jal         (i_jal),
        .i_jalr        (i_jalr),
        .i_mret        (i_mret),
        .i_ecall       (i_ecall),
        .i_pc          (i_pc),
        .i_rs1         (i_rs1),
        .i_imm         (i_imm),
        .i_res         (i_res),
        .i_mepc        (i_mepc),
        .i_mtvec       (i_mtvec),
        .o_rd_wdata    (o_rd_wdata),
        .o_csr_rd      (o_csr_rd),
        .o_wbu_wen     (o_wbu_wen),
        .o_wbu_csr_wen (o_wbu_csr_wen),
        .o_pc_update   (o_pc_update),
        .i_pc_ready    (i_pc_ready),
        .o_pc_next     (o_pc_next),
        .o_misalign    (o_misalign)
`ifdef WBU_INSTRET_EN
        ,
        .o_instret     (o_instret)
`endif
    );

    typedef struct {
        logic            wen;
        logic            csr_wen;
        logic [XLEN-1:0] rd;
        logic [XLEN-1:0] csr;
        logic [XLEN-1:0] npc;
        logic            mis;
    } exp_t;

    exp_t        sb[$];
    exp_t        last;
    int          checks = 0;
    int          errors = 0;
    logic        fresh = 1'b1;
    int          wen_pulses = 0;
    int          upd_cycles = 0;
    logic [63:0] exp_instret = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model();
        exp_t            e;
        logic [XLEN-1:0] seq;
        seq       = i_pc + 32'd4;
        e.wen     = i_wen;
        e.csr_wen = i_csr_wen;
        e.csr     = i_res;
        e.rd      = (i_jal || i_jalr) ? seq : i_res;
        if (i_ecall)                e.npc = i_mtvec;
        else if (i_mret)            e.npc = i_mepc;
        else if (i_jal)             e.npc = i_pc + i_imm;
        else if (i_jalr)            e.npc = (i_rs1 + i_imm) & 32'hFFFF_FFFE;
        else if (i_brch && i_res[0]) e.npc = i_pc + i_imm;
        else                        e.npc = seq;
        e.mis = (e.npc[1:0] != 2'b00);
        return e;
    endfunction

    always @(negedge clock) begin
        if (!reset_n) begin
            sb.delete();
            fresh       = 1'b1;
            exp_instret = 0;
        end else begin
`ifdef WBU_INSTRET_EN
            check("instret", o_instret, exp_instret);
`endif
            if (o_wbu_wen) wen_pulses++;
            if (o_pc_update) begin
                upd_cycles++;
                if (fresh) begin
                    if (sb.size() == 0) begin
                        check("commit_has_entry", 64'(sb.size()), 64'd1);
                    end else begin
                        last = sb.pop_front();
                        check("wen",      o_wbu_wen,     last.wen);
                        check("csr_wen",  o_wbu_csr_wen, last.csr_wen);
                        check("rd_wdata", o_rd_wdata,    last.rd);
                        check("csr_rd",   o_csr_rd,      last.csr);
                        check("pc_next",  o_pc_next,     last.npc);
                        check("misalign", o_misalign,    last.mis);
                    end
                end else begin
                    check("hold_wens",    {o_wbu_wen, o_wbu_csr_wen}, 2'b00);
                    check("hold_pc_next", o_pc_next, last.npc);
                end
                fresh = i_pc_ready;
                if (i_pc_ready) exp_instret++;
            end else begin
                check("idle_outputs", {o_wbu_wen, o_wbu_csr_wen, o_misalign}, 3'b000);
            end
            if (i_pre_valid && o_pre_ready) sb.push_back(model());
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_entry(input logic wen, input logic csr_wen, input logic brch,
                             input logic jal, input logic jalr, input logic mret,
                             input logic ecall, input logic [XLEN-1:0] pc,
                             input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] imm,
                             input logic [XLEN-1:0] res, input logic [XLEN-1:0] mepc,
                             input logic [XLEN-1:0] mtvec);
        i_wen = wen;   i_csr_wen = csr_wen; i_brch = brch; i_jal = jal;
        i_jalr = jalr; i_mret = mret;       i_ecall = ecall;
        i_pc = pc;     i_rs1 = rs1;         i_imm = imm;   i_res = res;
        i_mepc = mepc; i_mtvec = mtvec;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          p0, u0;
        logic [63:0] base;
        reset_n     = 1'b0;
        i_pre_valid = 1'b0;
        i_pc_ready  = 1'b1;
        set_entry(0, 0, 0, 0, 0, 0, 0, '0, '0, '0, '0, '0, '0);
        repeat (3) tick();
        reset_n = 1'b1;

        @(negedge clock);
        check("rst_pre_ready", o_pre_ready, 1'b1);
        check("rst_pc_update", o_pc_update, 1'b0);
        check("rst_wens",      {o_wbu_wen, o_wbu_csr_wen}, 2'b00);
        check("rst_misalign",  o_misalign, 1'b0);

        // Plain ALU result, sequential PC, then back to IDLE.
        tick();
        set_entry(1, 0, 0, 0, 0, 0, 0, 32'h0000_1000, 32'h0, 32'h0, 32'h55, 32'h0, 32'h0);
        i_pre_valid = 1'b1;
        tick();
        i_pre_valid = 1'b0;
        @(negedge clock);
        check("add_pc_next", o_pc_next, 32'h0000_1004);
        tick();
        @(negedge clock);
        check("add_then_idle", o_pc_update, 1'b0);

        // jalr clears bit 0 only, leaving a misaligned target.
        tick();
        set_entry(1, 0, 0, 0, 1, 0, 0, 32'h0000_2000, 32'h8000_0003, 32'h10, 32'h0, 32'h0, 32'h0);
        i_pre_valid = 1'b1;
        tick();
        i_pre_valid = 1'b0;
        @(negedge clock);
        check("jalr_pc_next",  o_pc_next,  32'h8000_0012);
        check("jalr_rd_wdata", o_rd_wdata, 32'h0000_2004);
        check("jalr_misalign", o_misalign, 1'b1);

        // Fetch stalls for three cycles after capture.
        tick();
        set_entry(1, 1, 1, 0, 0, 0, 0, 32'h0000_3000, 32'h0, 32'hFFFF_FFF8, 32'h1, 32'h0, 32'h0);
        i_pre_valid = 1'b1;
        i_pc_ready  = 1'b0;
        p0 = wen_pulses;
        u0 = upd_cycles;
        tick();
        i_pre_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("hold_pre_ready", o_pre_ready, 1'b0);
            check("hold_pc_update", o_pc_update, 1'b1);
            tick();
        end
        i_pc_ready = 1'b1;
        @(negedge clock);
        check("hold_release_ready", o_pre_ready, 1'b1);
        tick();
        tick();
        check("hold_wen_pulses", 64'(wen_pulses - p0), 64'd1);
        check("hold_upd_cycles", 64'(upd_cycles - u0), 64'd4);

        // Eight back-to-back entries of mixed control-flow classes.
        tick();
        p0   = wen_pulses;
        base = exp_instret;
        for (int i = 0; i < 8; i++) begin
            set_entry(1, i[0], (i % 4) == 2, (i % 4) == 1, (i % 4) == 3, 0, 0,
                      $urandom & 32'hFFFF_FFFC, $urandom, $urandom_range(0, 255) << 2,
                      $urandom, 32'h0, 32'h0);
            i_pre_valid = 1'b1;
            tick();
        end
        i_pre_valid = 1'b0;
        tick();
        tick();
        check("b2b_wen_pulses", 64'(wen_pulses - p0), 64'd8);
`ifdef WBU_INSTRET_EN
        check("b2b_instret", o_instret, base + 64'd8);
`endif

        // ecall outranks mret.
        set_entry(0, 0, 0, 0, 0, 1, 1, 32'h0000_4000, 32'h0, 32'h0, 32'h0, 32'h200, 32'h100);
        i_pre_valid = 1'b1;
        tick();
        i_pre_valid = 1'b0;
        @(negedge clock);
        check("ecall_pc_next", o_pc_next, 32'h0000_0100);
        tick();

        // Reset while the stage is holding an entry.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        set_entry(1, 1, 0, 0, 0, 0, 0, 32'h0000_5000, 32'h0, 32'h0, 32'h77, 32'h0, 32'h0);
        i_pre_valid = 1'b1;
        i_pc_ready  = 1'b0;
        tick();
        i_pre_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_hold_wens",      {o_wbu_wen, o_wbu_csr_wen}, 2'b00);
        check("rst_hold_pc_update", o_pc_update, 1'b0);
        check("rst_hold_pre_ready", o_pre_ready, 1'b1);
`ifdef WBU_INSTRET_EN
        check("rst_hold_instret", o_instret, 64'd0);
`endif
        i_pc_ready = 1'b1;
        tick();
        tick();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
